// File: rtl/perceptron_ctrl.sv
// perceptron_ctrl
// Sequencer for a 3-word perceptron weight memory (bias w0, w1, w2 in Q9).
// Each accepted start reads all weights and accumulates w0 + w1*x1 + w2*x2
// (each product in Q9). It then registers the class decision. In training
// mode a misclassification makes it write the perceptron-rule update back.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, honoured only in IDLE
//   train, x1, x2,      operation arguments, latched when start is accepted
//   target
//   busy, done          busy covers RD..DONE; done pulses in the DONE cycle
//   y_out, sum_out      decision and saturated sum, updated in DECIDE
//   mem_ena, wr_rd,     weight-memory port (synchronous, rdata one cycle
//   addr, wdata, rdata  after a read); addr/wdata hold while mem_ena=0
//   state_dbg           current FSM state, for observation only
//
// Memory handshake: the controller is the only master. A cycle with
// mem_ena=1 is an access: wr_rd=1 writes wdata to addr, wr_rd=0 reads addr
// and the word appears on rdata in the following cycle. There is no stall.
module perceptron_ctrl #(
   parameter int N_W  = 3,
   parameter int DW   = 16,
   parameter int FRAC = 9,
   parameter int AW   = 6,
   parameter int LR   = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          train,
   input  logic [DW-1:0] x1,
   input  logic [DW-1:0] x2,
   input  logic          target,
   output logic          busy,
   output logic          done,
   output logic          y_out,
   output logic [DW-1:0] sum_out,
   output logic          mem_ena,
   output logic          wr_rd,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata,
   input  logic [DW-1:0] rdata,
   output logic [2:0]    state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_LAST, S_DECIDE, S_WR, S_DONE
   } state_t;

   localparam logic signed [DW-1:0] ONE  = DW'(1 << FRAC);
   localparam logic signed [DW-1:0] LR_S = DW'(LR);
   localparam logic [1:0]           LAST_IDX = 2'(N_W - 1);
   localparam logic signed [2*DW-1:0] MAX_V = (2*DW)'((1 << (DW-1)) - 1);
   localparam logic signed [2*DW-1:0] MIN_V = -(2*DW)'(1 << (DW-1));

   function automatic logic signed [DW-1:0] sat(input logic signed [2*DW-1:0] v);
      if (v > MAX_V)      return MAX_V[DW-1:0];
      else if (v < MIN_V) return MIN_V[DW-1:0];
      else                return v[DW-1:0];
   endfunction

   state_t state, state_nx;
   logic [1:0] cnt;
   logic train_q, target_q;
   logic signed [DW-1:0] x1_q, x2_q, w0_q, w1_q, w2_q;
   logic signed [2*DW-1:0] acc;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;

   logic cap_en;
   logic [1:0] cap_idx;
   logic signed [DW-1:0] cap_x, wr_x, wr_w, upd_sat;
   logic signed [2*DW-1:0] prod, term, lr_prod, delta, upd;
   logic y_dec;

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign state_dbg = state;
   assign y_dec     = ~acc[2*DW-1];
   assign addr      = mem_ena ? AW'(cnt) : addr_q;
   assign wdata     = (mem_ena && wr_rd) ? upd_sat : wdata_q;

   always_comb begin
      state_nx = state;
      mem_ena  = 1'b0;
      wr_rd    = 1'b0;
      cap_en   = 1'b0;
      cap_idx  = cnt - 2'd1;
      case (state)
         S_IDLE:   if (start) state_nx = S_RD;
         S_RD: begin
            mem_ena = 1'b1;
            // rdata in RD cycle k carries the word read in cycle k-1
            cap_en  = (cnt != 2'd0);
            if (cnt == LAST_IDX) state_nx = S_LAST;
         end
         S_LAST: begin
            cap_en   = 1'b1;
            cap_idx  = LAST_IDX;
            state_nx = S_DECIDE;
         end
         S_DECIDE: state_nx = (train_q && (target_q != y_dec)) ? S_WR : S_DONE;
         S_WR: begin
            mem_ena = 1'b1;
            wr_rd   = 1'b1;
            if (cnt == LAST_IDX) state_nx = S_DONE;
         end
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Datapath: product of the captured weight and its input, in Q9.
   always_comb begin
      case (cap_idx)
         2'd0:    cap_x = ONE;
         2'd1:    cap_x = x1_q;
         default: cap_x = x2_q;
      endcase
      prod = $signed(rdata) * cap_x;
      term = prod >>> FRAC;
   end

   // Write-back value: err is +1 when target=1 (decision was 0), else -1.
   always_comb begin
      case (cnt)
         2'd0:    begin wr_x = ONE;  wr_w = w0_q; end
         2'd1:    begin wr_x = x1_q; wr_w = w1_q; end
         default: begin wr_x = x2_q; wr_w = w2_q; end
      endcase
      lr_prod = LR_S * wr_x;
      delta   = lr_prod >>> FRAC;
      upd     = $signed({{DW{wr_w[DW-1]}}, wr_w}) + (target_q ? delta : -delta);
      upd_sat = sat(upd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= 2'd0;
         train_q  <= 1'b0;
         target_q <= 1'b0;
         x1_q     <= '0;
         x2_q     <= '0;
         w0_q     <= '0;
         w1_q     <= '0;
         w2_q     <= '0;
         acc      <= '0;
         y_out    <= 1'b0;
         sum_out  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         if ((state == S_RD) || (state == S_WR))
            cnt <= (cnt == LAST_IDX) ? 2'd0 : cnt + 2'd1;
         else
            cnt <= 2'd0;

         if ((state == S_IDLE) && start) begin
            train_q  <= train;
            target_q <= target;
            x1_q     <= x1;
            x2_q     <= x2;
            acc      <= '0;
         end

         if (cap_en) begin
            acc <= acc + term;
            case (cap_idx)
               2'd0:    w0_q <= rdata;
               2'd1:    w1_q <= rdata;
               default: w2_q <= rdata;
            endcase
         end

         if (state == S_DECIDE) begin
            y_out   <= y_dec;
            sum_out <= sat(acc);
         end

         if (mem_ena) begin
            addr_q <= addr;
            if (wr_rd) wdata_q <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Testbench for perceptron_ctrl: synchronous weight-memory model, a
// reference model computing each operation's memory trace, decision and
// sum with plain integer arithmetic, and directed plus random operations.
module tb_perceptron_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        train = 1'b0;
   logic [15:0] x1 = '0;
   logic [15:0] x2 = '0;
   logic        target = 1'b0;
   logic        busy, done, y_out, mem_ena, wr_rd;
   logic [15:0] sum_out, wdata;
   logic [15:0] rdata = '0;
   logic [5:0]  addr;
   logic [2:0]  state_dbg;

   perceptron_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .train(train),
      .x1(x1), .x2(x2), .target(target), .busy(busy), .done(done),
      .y_out(y_out), .sum_out(sum_out), .mem_ena(mem_ena), .wr_rd(wr_rd),
      .addr(addr), .wdata(wdata), .rdata(rdata), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // weight memory
   logic [15:0] mem [64];
   always @(posedge clk) begin
      if (mem_ena) begin
         if (wr_rd) mem[addr] <= wdata;
         else       rdata     <= mem[addr];
      end
   end

   // scoreboard
   int checks = 0;
   int errors = 0;
   int t0 = 0;
   logic [31:0] obs_q[$];
   logic [31:0] exp_q[$];
   shortint ref_w [3];

   function automatic logic [31:0] pack(input int off, input logic wr,
                                        input logic [5:0] a, input logic [15:0] d);
      return {8'(off), wr, 1'b0, a, d};
   endfunction

   always @(negedge clk)
      if (mem_ena) obs_q.push_back(pack(cyc - t0, wr_rd, addr, wr_rd ? wdata : 16'h0));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic shortint sat16(input longint v);
      if (v > 32767)  return 16'sd32767;
      if (v < -32768) return -16'sd32768;
      return shortint'(v);
   endfunction

   // reference model: fills exp_q, updates ref_w, returns decision data
   task automatic model_op(input logic tr, input shortint a1, input shortint a2,
                           input logic tg, output logic [15:0] esum,
                           output logic ey, output int edone);
      longint acc, d;
      longint xs [3];
      int err;
      shortint nw;
      xs[0] = 512; xs[1] = a1; xs[2] = a2;
      acc = 0;
      for (int k = 0; k < 3; k++) acc += (longint'(ref_w[k]) * xs[k]) >>> 9;
      esum = sat16(acc);
      ey = (acc >= 0);
      exp_q.delete();
      for (int k = 0; k < 3; k++) exp_q.push_back(pack(1 + k, 1'b0, 6'(k), 16'h0));
      edone = 6;
      err = int'(tg) - int'(ey);
      if (tr && err != 0) begin
         for (int k = 0; k < 3; k++) begin
            d  = (longint'(256) * xs[k]) >>> 9;
            nw = sat16(longint'(ref_w[k]) + err * d);
            exp_q.push_back(pack(6 + k, 1'b1, 6'(k), nw));
            ref_w[k] = nw;
         end
         edone = 9;
      end
   endtask

   task automatic preload(input shortint a, input shortint b, input shortint c);
      mem[0] = a; mem[1] = b; mem[2] = c;
      ref_w[0] = a; ref_w[1] = b; ref_w[2] = c;
   endtask

   // driver: one operation, optionally pulsing start while busy and in DONE
   task automatic run_op(input logic tr, input shortint a1, input shortint a2,
                         input logic tg, input bit poke);
      logic [15:0] esum;
      logic ey;
      int edone, doff;
      bit got;
      model_op(tr, a1, a2, tg, esum, ey, edone);
      @(negedge clk);
      train = tr; x1 = a1; x2 = a2; target = tg; start = 1'b1;
      t0 = cyc;
      obs_q.delete();
      @(negedge clk);
      start = 1'b0;
      check("busy_rise", busy, 1);
      got = 0;
      doff = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            doff = cyc - t0;
         end
         start = poke && (got || ((cyc - t0) == 3));
      end
      if (!got) check("done_timeout", 0, 1);
      check("done_cycle", doff, edone);
      check("sum_out", sum_out, esum);
      check("y_out", y_out, ey);
      @(negedge clk);
      start = 1'b0;
      check("busy_fall", busy, 0);
      check("done_pulse", done, 0);
      repeat (3) @(negedge clk);
      check("trace_len", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("trace[%0d]", i), obs_q[i], exp_q[i]);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_y", y_out, 0);
      check("rst_sum", sum_out, 0);
      check("rst_mem_ena", mem_ena, 0);
      check("rst_wr_rd", wr_rd, 0);
      check("rst_addr", addr, 0);
      check("rst_wdata", wdata, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // inference
      preload(-256, 512, 512);
      run_op(1'b0, 0, 0, 1'b0, 0);
      // correct classification while training
      preload(-256, 512, 512);
      run_op(1'b1, 512, 0, 1'b1, 0);
      // misclassification update
      preload(-256, 512, 512);
      run_op(1'b1, 512, 0, 1'b0, 0);
      check("mem0_after_upd", mem[0], 16'hFE00);
      // saturation
      preload(32700, -32768, 0);
      run_op(1'b1, 32767, 0, 1'b1, 0);
      // start pulses during busy and in DONE are ignored
      preload(-256, 512, 512);
      run_op(1'b1, 512, 0, 1'b0, 1);

      // reset mid-operation
      @(negedge clk);
      train = 1'b0; x1 = 16'd100; x2 = 16'd200; target = 1'b0; start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_mem_ena", mem_ena, 0);
      check("abort_busy", busy, 0);
      check("abort_sum", sum_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b1, 1000, -700, 1'b1, 0);

      // random operations, weights sometimes carried over between updates
      for (int i = 0; i < 12; i++) begin
         if (i % 3 == 0)
            preload(shortint'($urandom), shortint'($urandom_range(0, 4095)) - 16'sd2048,
                    shortint'($urandom));
         run_op(1'($urandom_range(0, 1)), shortint'($urandom), shortint'($urandom),
                1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
